mem_loader: RTL
===============

# mem_loader

Boot-time program loader for the RISC-V core. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into the unified memory through its write port. While loading, it holds the core in reset. It releases the core once the image is complete. It drives the memory write side (`i_address`, `i_data_write`, `i_write_en`), muxed in ahead of the pipeline while `o_core_reset_n` is low.

## Interface

Parameters:

- `ADDR_W`, 32: memory address width (byte address).
- `DATA_W`, 32: memory word width; fixed at 4 bytes per word.
- `BASE_ADDR`, 0: byte address of the first word written.
- `MAX_WORDS`, 1024: largest legal image, in words.

Ports:

- `i_clk`  input  1: clock, single domain; all state updates on the rising edge.
- `i_reset`  input  1: asynchronous, active-high reset.
- `i_byte`  input  8: stream byte.
- `i_byte_valid`  input  1: `i_byte` is valid.
- `o_byte_ready`  output  1: loader accepts a byte. Transfer occurs on an edge where `i_byte_valid` and `o_byte_ready` are both 1.
- `i_reload`  input  1: restart loading. Honoured only in DONE or ERROR.
- `o_mem_addr`  output  ADDR_W: write address.
- `o_mem_data`  output  DATA_W: write data.
- `o_mem_write_en`  output  1: one-cycle write strobe.
- `o_core_reset_n`  output  1: 0 holds the core and PC in reset.
- `o_busy`  output  1: loading in progress (HDR, CHECK, DATA or WRITE).
- `o_done`  output  1: image loaded.
- `o_error`  output  1: header rejected.

## Operation

- Stream format:
  - 4-byte little-endian word count N.
  - Then N words, each 4 bytes, LSB first.
- States and transitions:
  - IDLE: 1 cycle → HDR.
  - HDR: accept 4 bytes into the count register; on the 4th accepted byte → CHECK.
  - CHECK: 1 cycle.
    - N > `MAX_WORDS` → ERROR.
    - N == 0 → DONE.
    - Otherwise set remaining = N, addr = `BASE_ADDR`, → DATA.
  - DATA: accept 4 bytes. Byte k (k = 0..3) goes to word bits [8k+7:8k]. On the 4th accepted byte → WRITE.
  - WRITE: `o_mem_write_en` = 1 for exactly one cycle, with `o_mem_addr` = addr and `o_mem_data` = the assembled word.
    - Next edge: addr += 4 (modulo 2^ADDR_W) and remaining -= 1.
    - Then → DONE if remaining was 1, else → DATA.
  - DONE: `o_done` = 1, `o_core_reset_n` = 1. `i_reload` → IDLE.
  - ERROR: `o_error` = 1, core held in reset. `i_reload` → IDLE.
- Output decode: `o_byte_ready`, `o_mem_write_en`, `o_busy`, `o_done`, `o_error` and `o_core_reset_n` are decoded from the state register only. There is no combinational path from any input to any output.
  - `o_byte_ready` = 1 only in HDR and DATA.
  - `o_core_reset_n` = 1 only in DONE.
- Byte counter: 2 bits, cleared on entry to HDR and to DATA.
- Byte acceptance: bytes presented outside HDR/DATA are not consumed. The source must hold `i_byte` stable until it is accepted.
- `i_reload` in any state other than DONE or ERROR is ignored.

## Timing

- Reset values (async assert): state IDLE, `o_byte_ready` 0, `o_mem_write_en` 0, `o_mem_addr` `BASE_ADDR`, `o_mem_data` 0, `o_core_reset_n` 0, `o_busy` 0, `o_done` 0, `o_error` 0.
- After reset release: the first edge enters HDR, so ready = 1 one cycle after release.
- Throughput: with valid held high, each word costs 5 cycles (4 accepts + 1 WRITE). A full N-word load takes 1 + 4 + 1 + 5N cycles from reset release to DONE.
- The write strobe for a word is asserted in the cycle immediately after its 4th byte is accepted.
- `o_core_reset_n` rises in the first cycle of DONE. It falls in the first cycle of IDLE after `i_reload`.
- Reset mid-operation: the partial word, count and address are discarded. `o_mem_write_en` drops immediately (async). No write is issued for an incomplete word.

## Test plan

- Stream 02 00 00 00, 13 00 00 00, 93 00 10 00 → two strobes: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. DONE and `o_core_reset_n` = 1 exactly 16 cycles after reset release.
- Stream 00 00 00 00 → no write strobe; `o_done` = 1 one cycle after CHECK; `o_byte_ready` = 0 thereafter.
- Count `MAX_WORDS`+1 (01 04 00 00 with default parameters) → ERROR. `o_error` = 1, no writes, `o_core_reset_n` stays 0, and subsequent bytes are never accepted.
- Random `i_byte_valid` gaps over a 3-word image → writes and data identical to the gap-free run. Ready is 0 in every WRITE cycle, and a held byte is accepted exactly once.
- Assert `i_reset` after 2 data bytes of word 1 → all outputs return to reset values within the cycle. A fresh stream then loads correctly starting at `BASE_ADDR`.
- In DONE, pulse `i_reload` → `o_core_reset_n` = 0 next cycle. A second 1-word image AB CD EF 01 writes 0x01EFCDAB to `BASE_ADDR`.

Source files
------------

// File: rtl/mem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into words,
// writes them sequentially to memory and holds the core in reset until done.
module mem_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  input  logic              i_reload,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_write_en,
  output logic              o_core_reset_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic ready_q, ready_d;
  logic we_q, we_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic core_rst_n_q, core_rst_n_d;

  logic accept;

  assign accept = i_byte_valid && ready_q;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    word_d      = word_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          count_d[{cnt_q, 3'b000} +: 8] = i_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (count_q > CNT_W'(MAX_WORDS)) begin
          state_d = S_ERROR;
        end else if (count_q == '0) begin
          state_d = S_DONE;
        end else begin
          remaining_d = count_q;
          addr_d      = BASE_ADDR;
          cnt_d       = '0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{cnt_q, 3'b000} +: 8] = i_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d      = addr_q + ADDR_W'(4);
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        if (i_reload) begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (i_reload) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered copies of the decode of the next state
  always_comb begin
    ready_d      = (state_d == S_HDR) || (state_d == S_DATA);
    we_d         = (state_d == S_WRITE);
    busy_d       = (state_d == S_HDR) || (state_d == S_CHECK) ||
                   (state_d == S_DATA) || (state_d == S_WRITE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    core_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      addr_q       <= BASE_ADDR;
      word_q       <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign o_byte_ready   = ready_q;
  assign o_mem_write_en = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_data     = word_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_core_reset_n = core_rst_n_q;

endmodule
